// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor A - B - Bin, LSB first, valid/ready on both sides.
// Define SUB_ABS_EN to report |A - B - Bin| in diff (bout still gives the sign).
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned     CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             cell_d;
  logic             cell_bout;

  full_subtractor_1bit u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    br_d        = br_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = A;
          b_d        = B;
          br_d       = Bin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        res_d = {cell_d, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = cell_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
`ifdef SUB_ABS_EN
        // Two's-complement negation; the 2^WIDTH magnitude wraps to 0 by design.
        diff_d = br_q ? (~res_q + WIDTH'(1)) : res_q;
`else
        diff_d = res_q;
`endif
        bout_d      = br_q;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are cleared too, so an aborted operation leaves no residue.
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      br_q        <= br_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing `A - B - Bin` over `WIDTH` clock cycles, one bit per cycle, LSB first. It is the inverse counterpart of the parallel adder circuit in the computation unit. The linear-regression datapath uses it to form residuals (y − ŷ) and gradient differences. Operands enter and results leave through valid/ready handshakes, so it can sit between the prediction stage and the error accumulator.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operand set `A`/`B`/`Bin` is valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `A`  in  WIDTH  minuend, unsigned.
- `B`  in  WIDTH  subtrahend, unsigned.
- `Bin`  in  1  borrow-in.
- `out_valid`  out  1  `diff`/`bout` valid.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  result, modulo 2^WIDTH (absolute value when `SUB_ABS_EN` is defined).
- `bout`  out  1  borrow-out: 1 when A < B + Bin, taking `Bin` as 0 or 1.

## Operation
- **States:** IDLE, SHIFT, FIX, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid` & `in_ready`: latch `A`, `B` and `Bin` into shift registers; load borrow register with `Bin`; clear bit counter; go to SHIFT.
- **SHIFT**, once per cycle:
  - Full-subtractor cell computes d = a0 ^ b0 ^ br and br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the MSB of the result register. A and B shift right. The borrow register takes br'.
  - After the counter reaches WIDTH−1, go to FIX.
- **FIX**
  - Always lasts exactly one cycle. This keeps the latency fixed with or without `SUB_ABS_EN`.
  - Without `SUB_ABS_EN`: copy the result register to `diff`.
  - With `SUB_ABS_EN`: apply the absolute-value correction described under Configuration.
  - `bout` takes the final borrow.
  - Go to DONE.
- **DONE**
  - `out_valid`=1.
  - On `out_ready`, go to IDLE.
  - `diff`/`bout` hold stable while `out_valid` & !`out_ready`.
- **Input acceptance:** `in_valid` is ignored outside IDLE. The block takes no new operands until the result has been accepted. No back-to-back overlap.
- **Reset:** `rst` wins in any state.
  - Next state is IDLE.
  - `diff`=0, `bout`=0, `out_valid`=0, `in_ready`=1.
  - Internal shift registers, borrow register and counter are cleared.
  - Any operation in flight is discarded. No partial result is ever presented.

## Timing
- Accept edge is T0 (`in_valid` & `in_ready` sampled high).
- SHIFT occupies the edges T1..T_WIDTH.
- FIX occupies edge T_WIDTH+1.
- `out_valid` is visible high after edge T_WIDTH+1, i.e. latency WIDTH+1 cycles (9 at the default).
- `in_ready` drops the cycle after T0 and returns high the cycle after the output handshake edge.
- Minimum issue interval is WIDTH+3 cycles with `out_ready` held high.
- `diff`/`bout` change only at the FIX edge and at reset.

## Configuration
- **`SUB_ABS_EN` defined:** in FIX, if borrow=1 then `diff` = (~result + 1) mod 2^WIDTH, else `diff` = result.
  - `bout` still reports the sign.
  - Corner case A=0, B=2^WIDTH−1, Bin=1: the magnitude 2^WIDTH does not fit, so `diff`=0 and `bout`=1.
- **`SUB_ABS_EN` undefined:** `diff` is the raw modulo result. The FIX cycle is still present.

## Structure
- Package `serial_subtractor_pkg` holds:
  - the state enum (IDLE, SHIFT, FIX, DONE);
  - the default `WIDTH`;
  - the counter-width function `$clog2(WIDTH)`.
- Sub-module `full_subtractor_1bit` (inputs `a`, `b`, `bin`; outputs `d`, `bout`) is the single combinational cell. It is instantiated once.

## Test plan
- **Basic subtract.** A=0x05, B=0x03, Bin=0 → `diff`=0x02, `bout`=0. `out_valid` rises exactly 9 cycles after the accept edge.
- **Negative result.** A=0x00, B=0x01, Bin=0 → `diff`=0xFF, `bout`=1. With `SUB_ABS_EN`: `diff`=0x01, `bout`=1.
- **Alternating bits with borrow-in.** A=0xAA, B=0x55, Bin=1 → `diff`=0x54, `bout`=0.
- **Equal operands, borrow-in, and ABS corner.**
  - A=0x10, B=0x10, Bin=1 → `diff`=0xFF, `bout`=1 (ABS: 0x01).
  - A=0x00, B=0xFF, Bin=1 → ABS `diff`=0x00, `bout`=1.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles in DONE while driving new `in_valid` → `diff`/`bout` stay stable and `in_ready`=0. The new operands are not taken until after the output handshake.
- **Reset mid-operation.** Assert `rst` on the 4th SHIFT cycle → next cycle shows `in_ready`=1, `out_valid`=0, `diff`=0. A fresh operation 0x09−0x04 then returns `diff`=0x05 with normal latency.
